// File: rtl/mem_pkg.sv
// Shared widths and enum types for the memory responder and its storage array.
package mem_pkg;
  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/mem_array.sv
// Byte storage with synchronous write, combinational read and asynchronous clear.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// Request/ready memory responder: latches a request, waits WAIT_CYCLES, then
// commits the write or captures read data and pulses ready for one cycle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              busy,
  output logic              err
);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t            state;
  op_t               op_q;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata;
  logic              we;

  // The array write lands on the same edge that raises ready.
  assign we   = (state == BUSY) && (cnt == '0) && (op_q == OP_WRITE);
  assign busy = (state != IDLE);

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(addr_q),
    .raddr(addr_q),
    .wdata(data_q),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_READ;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      data_out <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (read ^ write) begin
            addr_q <= addr;
            data_q <= data_in;
            op_q   <= write ? OP_WRITE : OP_READ;
            cnt    <= WAIT_INIT;
            state  <= BUSY;
          end else if (read && write) begin
            err <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (op_q == OP_READ) data_out <= rdata;
            ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for two responders (WAIT_CYCLES 2 and 0) against an array model.
module tb_mem_responder;
  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] rd = '0;
  logic [1:0] wr = '0;
  logic [4:0] ad [2];
  logic [7:0] di [2];
  logic [7:0] dout [2];
  logic       rdy [2];
  logic       bsy [2];
  logic       er [2];

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] model [2][32];
  logic [7:0] last_rd [2];
  int         last_start [2];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_rdy = 0;
  int         n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .read(rd[0]), .write(wr[0]), .addr(ad[0]),
    .data_in(di[0]), .data_out(dout[0]), .ready(rdy[0]), .busy(bsy[0]), .err(er[0])
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .read(rd[1]), .write(wr[1]), .addr(ad[1]),
    .data_in(di[1]), .data_out(dout[1]), .ready(rdy[1]), .busy(bsy[1]), .err(er[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int s, input exp_t e);
    if (s == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(input int s);
    exp_t e;
    bit   have;
    if (rdy[s] || er[s]) begin
      have = (s == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (!have) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output dut%0d: got ready=%0b err=%0b expected none", s, rdy[s], er[s]);
      end else begin
        if (s == 0) e = q0.pop_front();
        else e = q1.pop_front();
        if (er[s]) begin
          n_err++;
          check($sformatf("err_kind dut%0d", s), e.kind, K_ERR);
        end else begin
          n_rdy++;
          check($sformatf("ready_kind dut%0d", s), (e.kind == K_ERR) ? 1 : 0, 0);
          check($sformatf("data_out dut%0d", s), dout[s], e.data);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic access(input int s, input bit is_wr, input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    int   lat;
    int   bcnt;
    int   start;
    int   ws;
    ws = (s == 0) ? 2 : 0;
    last_start[1-s] = -1;
    if (is_wr) begin
      model[s][a] = d;
      e.kind = K_WR;
      e.data = last_rd[s];
    end else begin
      e.kind = K_RD;
      e.data = model[s][a];
      last_rd[s] = e.data;
    end
    push(s, e);
    rd[s] = !is_wr;
    wr[s] = is_wr;
    ad[s] = a;
    di[s] = d;
    @(posedge clk);
    @(negedge clk);
    start = cyc;
    bcnt = int'(bsy[s]);
    lat = 0;
    while (!rdy[s] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bcnt += int'(bsy[s]);
    end
    check($sformatf("latency dut%0d", s), lat, ws + 1);
    rd[s] = 1'b0;
    wr[s] = 1'b0;
    ad[s] = 5'($urandom);
    di[s] = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("busy_cycles dut%0d", s), bcnt, ws + 2);
    check($sformatf("busy_end dut%0d", s), bsy[s], 0);
    check($sformatf("ready_width dut%0d", s), rdy[s], 0);
    if (last_start[s] >= 0) check($sformatf("period dut%0d", s), start - last_start[s], ws + 3);
    last_start[s] = start;
  endtask

  task automatic illegal(input int s, input logic [4:0] a);
    exp_t e;
    e.kind = K_ERR;
    e.data = '0;
    push(s, e);
    rd[s] = 1'b1;
    wr[s] = 1'b1;
    ad[s] = a;
    di[s] = 8'h77;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("err_busy dut%0d", s), bsy[s], 0);
    check($sformatf("err_high dut%0d", s), er[s], 1);
    rd[s] = 1'b0;
    wr[s] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("err_clear dut%0d", s), er[s], 0);
    check($sformatf("err_idle dut%0d", s), bsy[s], 0);
    last_start[s] = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd = '0;
    wr = '0;
    q0.delete();
    q1.delete();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 32; i++) model[s][i] = '0;
      last_rd[s] = '0;
      last_start[s] = -1;
    end
    repeat (2) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        check($sformatf("rst_ready dut%0d", s), rdy[s], 0);
        check($sformatf("rst_err dut%0d", s), er[s], 0);
        check($sformatf("rst_busy dut%0d", s), bsy[s], 0);
        check($sformatf("rst_data dut%0d", s), dout[s], 0);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int base_rdy;
    int base_err;
    ad[0] = '0; ad[1] = '0; di[0] = '0; di[1] = '0;
    @(negedge clk);
    do_reset();

    // random traffic, then a mid-run reset and a full read-back of zeros
    for (int i = 0; i < 20; i++) access(0, 1'($urandom), 5'($urandom), 8'($urandom));
    do_reset();
    for (int i = 0; i < 32; i++) access(0, 1'b0, 5'(i), 8'h00);

    access(0, 1'b1, 5'd5, 8'hA5);
    access(0, 1'b0, 5'd5, 8'h00);
    check("rd_after_wr_a5", dout[0], 8'hA5);

    base_rdy = n_rdy;
    base_err = n_err;
    for (int i = 0; i < 32; i++) access(0, 1'b1, 5'(i), 8'(i));
    for (int i = 0; i < 32; i++) access(0, 1'b0, 5'(i), 8'h00);
    check("sweep_ready_count", n_rdy - base_rdy, 64);
    check("sweep_err_count", n_err - base_err, 0);

    do_reset();
    illegal(0, 5'd3);
    access(0, 1'b0, 5'd3, 8'h00);
    check("illegal_no_write", dout[0], 8'h00);

    // write in flight when reset hits must be discarded
    access(0, 1'b1, 5'd9, 8'h11);
    access(0, 1'b0, 5'd9, 8'h00);
    wr[0] = 1'b1;
    ad[0] = 5'd7;
    di[0] = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", bsy[0], 1);
    base_rdy = n_rdy;
    do_reset();
    check("rst_mid_no_ready", n_rdy - base_rdy, 0);
    access(0, 1'b0, 5'd7, 8'h00);
    check("rst_mid_rd7", dout[0], 8'h00);

    // zero wait states
    access(1, 1'b1, 5'd31, 8'hFF);
    access(1, 1'b0, 5'd31, 8'h00);
    check("w0_rd31", dout[1], 8'hFF);
    for (int i = 0; i < 30; i++) access(1, 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom));
    illegal(1, 5'd2);
    for (int i = 0; i < 20; i++) access(0, 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom));

    repeat (4) @(negedge clk);
    check("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory responder for the read/write memory interface. It serves the 32 x 8 read/write protocol driven by the memory test initiator, holding a 32-entry byte array behind a request/ready handshake. A programmable wait-state counter sets the response latency, and a protocol-error flag catches illegal requests. It replaces the zero-latency behavioural memory wherever handshake timing must be exercised.

## Interface
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32
- DATA_W, 8, data width
- WAIT_CYCLES, 2, extra busy cycles per access (0..15 legal)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- read  input  1  read request, held until ready observed
- write  input  1  write request, held until ready observed
- addr  input  ADDR_W  request address, stable while request held
- data_in  input  DATA_W  write data, stable while request held
- data_out  output  DATA_W  read data, valid when ready=1 after a read
- ready  output  1  one-cycle access-complete pulse
- busy  output  1  high whenever state != IDLE
- err  output  1  one-cycle pulse on illegal request (read and write both high)

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE**
  - read XOR write at a rising edge: latch addr, data_in and op; cnt <= WAIT_CYCLES; go to BUSY.
  - read AND write: err <= 1 for one cycle, no access, stay IDLE.
  - Neither high: stay IDLE.
- **BUSY**
  - cnt != 0: cnt <= cnt - 1.
  - cnt == 0:
    - Write: array[addr_q] <= data_q.
    - Read: data_out <= array[addr_q].
    - In both cases ready <= 1 and go to DONE.
- **DONE:** ready <= 0; go to IDLE. Requests are not sampled in DONE.
- **Requests during BUSY/DONE:** inputs are ignored; only latched values are used.
- **data_out:** holds the last read value; writes do not change it.
- **Address:** full range, no wrap logic needed; a 5-bit address covers exactly 32 entries.
- **Reset (any time, including mid-access):**
  - State goes to IDLE, cnt = 0.
  - ready, err, busy = 0; data_out = 0.
  - All 32 array entries = 0.
  - An in-flight write is discarded.

## Timing
- Request sampled at edge k:
  - busy = 1 from edge k.
  - Write commit, data_out update and ready = 1 at edge k+1+WAIT_CYCLES.
  - ready = 0 and busy = 0 at edge k+2+WAIT_CYCLES.
- Latency from sample to ready = WAIT_CYCLES+1 cycles; ready width is exactly 1 cycle.
- **Initiator rule:** deassert read/write before the edge following the ready pulse. A request still high at the first IDLE edge starts a new access.
- **Back-to-back:** minimum request-to-request period is WAIT_CYCLES+3 cycles.
- **err timing:** err rises at the sampling edge and clears at the next edge. A held illegal request re-pulses err every cycle.
- **Read-after-write, same address:** returns the new data, since the write committed in an earlier access.

## Structure
- **Package mem_pkg:**
  - ADDR_W and DATA_W defaults.
  - State enum type (IDLE, BUSY, DONE).
  - Op enum type (OP_READ, OP_WRITE).
- **Sub-module mem_array:**
  - Ports: clk, rst_n, we, waddr/raddr, wdata, rdata.
  - Synchronous write, combinational read, async clear.
- **mem_responder:** holds the FSM, wait counter, request latches and output registers.

## Test plan
- **Reset state:** assert rst_n=0 mid-run, then release.
  - Required: ready/err/busy/data_out = 0.
  - Required: reading addresses 0..31 returns 8'h00 for all.
- **Write then read, WAIT_CYCLES=2:** write addr 5 = 8'hA5, then read addr 5.
  - Required: ready at exactly the 3rd edge after sampling; data_out = 8'hA5.
  - Required: busy high for 4 cycles.
- **Data = address sweep:** write i to addresses 0..31, then read all.
  - Required: each read returns i.
  - Required: 32+32 ready pulses, no err.
- **Illegal request:** read=1 and write=1 at addr 3 for one cycle.
  - Required: err pulses 1 cycle; busy stays 0; array[3] unchanged (reads 8'h00 after reset).
- **Reset during write:** start write addr 7 = 8'h3C, assert rst_n=0 while busy, release, read addr 7.
  - Required: returns 8'h00; no ready pulse during reset.
- **Latency with WAIT_CYCLES=0:** write addr 31 = 8'hFF.
  - Required: ready 1 edge after sampling; a read of addr 31 returns 8'hFF.
  - Required: the back-to-back period is 3 cycles.
